// File: rtl/onchip_ram_param.sv
// Parametrised Avalon-MM on-chip RAM slave with post-reset clear engine and readdatavalid.
// Define ONCHIP_RAM_OUTREG_EN to add a second output register stage (read latency 2).
module onchip_ram_param #(
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    ADDR_WIDTH  = 11,
    parameter int                    DEPTH       = 2048,
    parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = {DATA_WIDTH{1'b0}}
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [ADDR_WIDTH-1:0]     address,
    input  logic [DATA_WIDTH/8-1:0]   byteenable,
    input  logic                      chipselect,
    input  logic                      clken,
    input  logic                      read,
    input  logic                      write,
    input  logic [DATA_WIDTH-1:0]     writedata,
    output logic [DATA_WIDTH-1:0]     readdata,
    output logic                      readdatavalid,
    output logic                      waitrequest,
    output logic                      init_done
);

    localparam int LANES = DATA_WIDTH / 8;
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_t;

    state_t                  state_r;
    state_t                  state_s;
    logic [IDX_W-1:0]        ptr_r;
    logic                    clear_last_s;
    logic                    waitrequest_s;
    logic                    init_done_s;
    logic                    waitrequest_r;
    logic                    init_done_r;
    logic                    accept_s;
    logic                    rd_acc_s;
    logic                    wr_acc_s;
    logic                    in_range_s;
    logic [IDX_W-1:0]        idx_s;
    logic [DATA_WIDTH-1:0]   rd_word_s;
    logic                    vld1_r;
    logic [DATA_WIDTH-1:0]   data1_r;

    logic [DATA_WIDTH-1:0]   mem [DEPTH];

    function automatic logic [DATA_WIDTH-1:0] merge_lanes(
        input logic [DATA_WIDTH-1:0] old_word,
        input logic [DATA_WIDTH-1:0] new_word,
        input logic [LANES-1:0]      lane_en
    );
        logic [DATA_WIDTH-1:0] res;
        res = old_word;
        for (int i = 0; i < LANES; i++) begin
            if (lane_en[i]) begin
                res[8*i +: 8] = new_word[8*i +: 8];
            end else begin
                res[8*i +: 8] = old_word[8*i +: 8];
            end
        end
        return res;
    endfunction

    // Bus request decode; requests are only honoured once the clear engine is done.
    always_comb begin
        in_range_s   = ({1'b0, address} < (ADDR_WIDTH + 1)'(DEPTH));
        idx_s        = address[IDX_W-1:0];
        clear_last_s = (ptr_r == IDX_W'(DEPTH - 1));
        accept_s     = (state_r == ST_READY) & chipselect & clken & (read | write) & ~reset;
        wr_acc_s     = accept_s & write & in_range_s;
        rd_acc_s     = accept_s & read & ~write;
        if (in_range_s) begin
            rd_word_s = mem[idx_s];
        end else begin
            rd_word_s = {DATA_WIDTH{1'b0}};
        end
    end

    // FSM state register and clear pointer; clear runs regardless of clken.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_CLEAR;
            ptr_r   <= {IDX_W{1'b0}};
        end else begin
            state_r <= state_s;
            if (state_r == ST_CLEAR) begin
                ptr_r <= ptr_r + IDX_W'(1);
            end
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_CLEAR: begin
                if (clear_last_s) begin
                    state_s = ST_READY;
                end else begin
                    state_s = ST_CLEAR;
                end
            end
            ST_READY: state_s = ST_READY;
            default:  state_s = ST_CLEAR;
        endcase
    end

    // FSM outputs, decoded from the next state so the registered copies line up with it.
    always_comb begin
        waitrequest_s = 1'b1;
        init_done_s   = 1'b0;
        case (state_s)
            ST_CLEAR: begin
                waitrequest_s = 1'b1;
                init_done_s   = 1'b0;
            end
            ST_READY: begin
                waitrequest_s = 1'b0;
                init_done_s   = 1'b1;
            end
            default: begin
                waitrequest_s = 1'b1;
                init_done_s   = 1'b0;
            end
        endcase
    end

    // Registered status outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            waitrequest_r <= 1'b1;
            init_done_r   <= 1'b0;
        end else begin
            waitrequest_r <= waitrequest_s;
            init_done_r   <= init_done_s;
        end
    end

    // Memory array: clear engine fill, then lane-masked bus writes.
    always_ff @(posedge clk) begin
        if (!reset && state_r == ST_CLEAR) begin
            mem[ptr_r] <= CLEAR_VALUE;
        end else if (wr_acc_s) begin
            mem[idx_s] <= merge_lanes(mem[idx_s], writedata, byteenable);
        end
    end

    // First read stage; data holds its last value when no read is accepted.
    always_ff @(posedge clk) begin
        if (reset) begin
            vld1_r  <= 1'b0;
            data1_r <= {DATA_WIDTH{1'b0}};
        end else if (clken) begin
            vld1_r <= rd_acc_s;
            if (rd_acc_s) begin
                data1_r <= rd_word_s;
            end
        end
    end

`ifdef ONCHIP_RAM_OUTREG_EN
    logic                  vld2_r;
    logic [DATA_WIDTH-1:0] data2_r;

    // Optional second output stage, frozen by clken like the first.
    always_ff @(posedge clk) begin
        if (reset) begin
            vld2_r  <= 1'b0;
            data2_r <= {DATA_WIDTH{1'b0}};
        end else if (clken) begin
            vld2_r <= vld1_r;
            if (vld1_r) begin
                data2_r <= data1_r;
            end
        end
    end

    assign readdata      = data2_r;
    assign readdatavalid = vld2_r & clken;
`else
    assign readdata      = data1_r;
    assign readdatavalid = vld1_r & clken;
`endif

    assign waitrequest = waitrequest_r;
    assign init_done   = init_done_r;

endmodule

// File: tb/tb_onchip_ram_param.sv
// Scoreboard bench for onchip_ram_param (DEPTH=16, CLEAR_VALUE=0xA5A5A5A5).
module tb_onchip_ram_param;

`ifdef ONCHIP_RAM_OUTREG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif
    localparam logic [31:0] CV = 32'hA5A5A5A5;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [10:0] address = 11'd0;
    logic [3:0]  byteenable = 4'h0;
    logic        chipselect = 1'b1;
    logic        clken = 1'b1;
    logic        read = 1'b0;
    logic        write = 1'b0;
    logic [31:0] writedata = 32'h0;
    logic [31:0] readdata;
    logic        readdatavalid;
    logic        waitrequest;
    logic        init_done;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    logic [31:0] exp_data[$];
    int          exp_due[$];

    onchip_ram_param #(
        .DATA_WIDTH (32),
        .ADDR_WIDTH (11),
        .DEPTH      (16),
        .CLEAR_VALUE(CV)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .address      (address),
        .byteenable   (byteenable),
        .chipselect   (chipselect),
        .clken        (clken),
        .read         (read),
        .write        (write),
        .writedata    (writedata),
        .readdata     (readdata),
        .readdatavalid(readdatavalid),
        .waitrequest  (waitrequest),
        .init_done    (init_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h", nm, got, want);
        end
    endtask

    // Monitor: every readdatavalid pulse must match the oldest expectation, in its due cycle.
    always @(negedge clk) begin
        logic [31:0] d;
        int          due;
        if (exp_due.size() > 0 && exp_due[0] < cyc) begin
            total++;
            bad++;
            $display("FAIL missing_valid cycle=%0d due=%0d want=%h", cyc, exp_due[0], exp_data[0]);
            void'(exp_data.pop_front());
            void'(exp_due.pop_front());
        end
        if (readdatavalid === 1'b1) begin
            total++;
            if (exp_data.size() == 0) begin
                bad++;
                $display("FAIL unexpected_valid cycle=%0d got=%h want=none", cyc, readdata);
            end else begin
                d   = exp_data.pop_front();
                due = exp_due.pop_front();
                if (readdata !== d || cyc != due) begin
                    bad++;
                    $display("FAIL read_data got=%h@%0d want=%h@%0d", readdata, cyc, d, due);
                end
            end
        end
    end

    // One bus cycle; reads (without write) register an expectation when push is set.
    task automatic bus(input logic rd, input logic wr, input logic [10:0] a, input logic [31:0] d,
                       input logic [3:0] be, input int extra, input logic [31:0] ex, input bit push);
        read = rd; write = wr; address = a; writedata = d; byteenable = be;
        if (push && rd && !wr) begin
            exp_data.push_back(ex);
            exp_due.push_back(cyc + LAT + extra);
        end
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        read = 1'b0; write = 1'b0;
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic wait_clear(input string nm);
        int n;
        n = 0;
        while (waitrequest === 1'b1 && n < 100) begin
            chk({nm, "_init_low"}, {31'd0, init_done}, 32'd0);
            @(posedge clk); #1;
            n++;
        end
        chk({nm, "_clear_cycles"}, n, 32'd16);
        chk({nm, "_init_done"}, {31'd0, init_done}, 32'd1);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_readdata", readdata, 32'h0);
        chk("rst_rdvalid", {31'd0, readdatavalid}, 32'd0);
        chk("rst_waitreq", {31'd0, waitrequest}, 32'd1);
        chk("rst_init_done", {31'd0, init_done}, 32'd0);
        reset = 1'b0;
        wait_clear("clr1");

        // Every location holds the clear value.
        for (int i = 0; i < 16; i++) bus(1'b1, 1'b0, 11'(i), 32'h0, 4'h0, 0, CV, 1'b1);
        idle(3);

        // Lane-masked writes followed immediately by a read of the same word.
        bus(1'b0, 1'b1, 11'd5, 32'h11223344, 4'hF, 0, 32'h0, 1'b0);
        bus(1'b0, 1'b1, 11'd5, 32'hFFFFFFFF, 4'h5, 0, 32'h0, 1'b0);
        bus(1'b1, 1'b0, 11'd5, 32'h0, 4'h0, 0, 32'h11FF33FF, 1'b1);
        idle(3);

        // Distinct words, a byteenable=0 write, then back-to-back reads.
        bus(1'b0, 1'b1, 11'd0, 32'h01010101, 4'hF, 0, 32'h0, 1'b0);
        bus(1'b0, 1'b1, 11'd1, 32'h02020202, 4'hF, 0, 32'h0, 1'b0);
        bus(1'b0, 1'b1, 11'd2, 32'h03030303, 4'hF, 0, 32'h0, 1'b0);
        bus(1'b0, 1'b1, 11'd3, 32'h04040404, 4'hF, 0, 32'h0, 1'b0);
        bus(1'b0, 1'b1, 11'd3, 32'hCAFEF00D, 4'h0, 0, 32'h0, 1'b0);
        bus(1'b1, 1'b0, 11'd0, 32'h0, 4'h0, 0, 32'h01010101, 1'b1);
        bus(1'b1, 1'b0, 11'd1, 32'h0, 4'h0, 0, 32'h02020202, 1'b1);
        bus(1'b1, 1'b0, 11'd2, 32'h0, 4'h0, 0, 32'h03030303, 1'b1);
        bus(1'b1, 1'b0, 11'd3, 32'h0, 4'h0, 0, 32'h04040404, 1'b1);
        idle(3);

        // Read held off by three cycles of clken low.
        bus(1'b1, 1'b0, 11'd1, 32'h0, 4'h0, 3, 32'h02020202, 1'b1);
        read = 1'b0;
        clken = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        clken = 1'b1;
        idle(3);

        // A write with clken low is ignored.
        clken = 1'b0;
        bus(1'b0, 1'b1, 11'd4, 32'h12345678, 4'hF, 0, 32'h0, 1'b0);
        clken = 1'b1;
        bus(1'b1, 1'b0, 11'd4, 32'h0, 4'h0, 0, CV, 1'b1);
        idle(3);

        // Simultaneous read+write: write wins, no response; out-of-range read returns 0.
        bus(1'b1, 1'b1, 11'd2, 32'hDEADBEEF, 4'hF, 0, 32'h0, 1'b1);
        bus(1'b1, 1'b0, 11'd2, 32'h0, 4'h0, 0, 32'hDEADBEEF, 1'b1);
        bus(1'b0, 1'b1, 11'd20, 32'h77777777, 4'hF, 0, 32'h0, 1'b0);
        bus(1'b1, 1'b0, 11'd20, 32'h0, 4'h0, 0, 32'h0, 1'b1);
        bus(1'b1, 1'b0, 11'd4, 32'h0, 4'h0, 0, CV, 1'b1);
        idle(3);

        // Reset during a read and again mid-clear at pointer 7.
        bus(1'b1, 1'b0, 11'd3, 32'h0, 4'h0, 0, 32'h04040404, (LAT == 1));
        read = 1'b0;
        reset = 1'b1;
        @(posedge clk); #1;
        chk("mid_rst_rdvalid", {31'd0, readdatavalid}, 32'd0);
        chk("mid_rst_readdata", readdata, 32'h0);
        chk("mid_rst_waitreq", {31'd0, waitrequest}, 32'd1);
        reset = 1'b0;
        repeat (7) begin @(posedge clk); #1; end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        wait_clear("clr2");
        bus(1'b1, 1'b0, 11'd5, 32'h0, 4'h0, 0, CV, 1'b1);
        bus(1'b1, 1'b0, 11'd15, 32'h0, 4'h0, 0, CV, 1'b1);
        idle(5);

        chk("queue_drained", exp_data.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
